// File: rtl/val2_shifter_pipe_pkg.sv
// Shared types for the pipelined Val2 operand generator.
// Shift-type and mode encodings, plus the saturated shift-amount width rule.
package val2_shifter_pipe_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    MEM,
    IMM_ROT,
    SH_IMM,
    SH_REG
  } mode_t;

  function automatic int unsigned shamt_width(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/val2_shifter_pipe_if.sv
// Request/response bundle of the Val2 shifter pipe.
// The master side issues requests and consumes results.
interface val2_shifter_pipe_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rm;
  logic [7:0]        rs;
  logic [11:0]       shift_operand;
  logic              immd;
  logic              is_mem_command;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] val2_out;
  logic              carry_out;

  modport master (
    output in_valid, rm, rs, shift_operand, immd, is_mem_command, carry_in, out_ready,
    input  in_ready, out_valid, val2_out, carry_out
  );

  modport slave (
    input  in_valid, rm, rs, shift_operand, immd, is_mem_command, carry_in, out_ready,
    output in_ready, out_valid, val2_out, carry_out
  );
endinterface

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter producing val2 and the shifter carry-out
// from an already decoded mode, saturated amount and shift type.
module val2_shift_core
  import val2_shifter_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = shamt_width(DATA_W)
) (
  input  mode_t              mode,
  input  logic [SHAMT_W-1:0] amount,
  input  shift_t             shift_type,
  input  logic [DATA_W-1:0]  rm,
  input  logic               carry_in,
  output logic [DATA_W-1:0]  val2,
  output logic               carry
);
  localparam int unsigned LOG_W = $clog2(DATA_W);
  localparam logic [SHAMT_W-1:0] AMT_W = SHAMT_W'(DATA_W);

  logic [SHAMT_W-1:0]      eff;
  logic                    over;
  logic [DATA_W:0]         lsl_ext;
  logic [DATA_W:0]         lsr_ext;
  logic signed [DATA_W:0]  asr_ext;
  logic [DATA_W-1:0]       rot;

  // Extra bit on each shifter captures the last bit shifted out as carry.
  always_comb begin
    over    = amount > AMT_W;
    eff     = over ? AMT_W : amount;
    lsl_ext = {1'b0, rm};
    lsr_ext = {rm, 1'b0};
    asr_ext = {rm, 1'b0};
    rot     = rm;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (eff[i]) begin
        lsl_ext = lsl_ext << (1 << i);
        lsr_ext = lsr_ext >> (1 << i);
        asr_ext = asr_ext >>> (1 << i);
      end
    end
    for (int unsigned i = 0; i < LOG_W; i++) begin
      if (amount[i]) begin
        rot = (rot >> (1 << i)) | (rot << (DATA_W - (1 << i)));
      end
    end
  end

  always_comb begin
    val2  = '0;
    carry = carry_in;
    case (mode)
      MEM: val2 = rm;
      IMM_ROT: begin
        val2 = rot;
        if (amount != '0) carry = rot[DATA_W-1];
      end
      default: begin
        if (amount == '0) begin
          if (mode == SH_IMM && shift_type == ROR) begin
            val2  = {carry_in, rm[DATA_W-1:1]};
            carry = rm[0];
          end else begin
            val2 = rm;
          end
        end else begin
          case (shift_type)
            LSL: begin
              val2  = over ? '0 : lsl_ext[DATA_W-1:0];
              carry = over ? 1'b0 : lsl_ext[DATA_W];
            end
            LSR: begin
              val2  = over ? '0 : lsr_ext[DATA_W:1];
              carry = over ? 1'b0 : lsr_ext[0];
            end
            ASR: begin
              val2  = asr_ext[DATA_W:1];
              carry = asr_ext[0];
            end
            default: begin
              val2  = rot;
              carry = rot[DATA_W-1];
            end
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/val2_shifter_pipe.sv
// Two-stage Val2 operand generator: S1 decodes and saturates the shift amount,
// S2 registers the barrel-shifter result; valid/ready with full throughput.
module val2_shifter_pipe
  import val2_shifter_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = shamt_width(DATA_W)
) (
  input logic clk,
  input logic rst,
  val2_shifter_pipe_if.slave bus
);
  shift_t             typ;
  mode_t              mode_d;
  logic [SHAMT_W-1:0] amt_d;
  logic [DATA_W-1:0]  rm_d;
  int unsigned        raw;

  logic               s1_valid;
  mode_t              s1_mode;
  logic [SHAMT_W-1:0] s1_amt;
  shift_t             s1_type;
  logic [DATA_W-1:0]  s1_rm;
  logic               s1_carry;

  logic               s2_valid;
  logic [DATA_W-1:0]  s2_val2;
  logic               s2_carry;
  logic               s2_advance;
  logic               in_ready;

  logic [DATA_W-1:0]  core_val2;
  logic               core_carry;

  assign typ = shift_t'(bus.shift_operand[6:5]);

  // Immediate/offset forms reuse the rm slot; ROR amounts are folded mod W
  // (W standing for a nonzero multiple) so saturation never loses rotate info.
  always_comb begin
    raw    = 0;
    mode_d = SH_IMM;
    rm_d   = bus.rm;
    amt_d  = '0;
    if (bus.is_mem_command) begin
      mode_d = MEM;
      rm_d   = DATA_W'(bus.shift_operand);
    end else if (bus.immd) begin
      mode_d = IMM_ROT;
      rm_d   = DATA_W'(bus.shift_operand[7:0]);
      amt_d  = SHAMT_W'({bus.shift_operand[11:8], 1'b0});
    end else begin
      if (bus.shift_operand[4]) begin
        mode_d = SH_REG;
        raw    = 32'(bus.rs);
      end else begin
        raw = 32'(bus.shift_operand[11:7]);
        if (raw == 0 && (typ == LSR || typ == ASR)) raw = DATA_W;
      end
      if (typ == ROR && raw != 0)
        raw = ((raw & (DATA_W - 1)) == 0) ? DATA_W : (raw & (DATA_W - 1));
      amt_d = (raw > DATA_W) ? SHAMT_W'(DATA_W + 1) : SHAMT_W'(raw);
    end
  end

  assign s2_advance = !s2_valid || bus.out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MEM;
      s1_amt   <= '0;
      s1_type  <= LSL;
      s1_rm    <= '0;
      s1_carry <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode  <= mode_d;
        s1_amt   <= amt_d;
        s1_type  <= typ;
        s1_rm    <= rm_d;
        s1_carry <= bus.carry_in;
      end
    end
  end

  val2_shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .mode       (s1_mode),
    .amount     (s1_amt),
    .shift_type (s1_type),
    .rm         (s1_rm),
    .carry_in   (s1_carry),
    .val2       (core_val2),
    .carry      (core_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_val2  <= '0;
      s2_carry <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_val2  <= core_val2;
        s2_carry <= core_carry;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.val2_out  = s2_val2;
  assign bus.carry_out = s2_carry;

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Bench for val2_shifter_pipe: directed ARM corner cases, backpressure, mid-stream
// reset and randomized traffic, all scored against a rule-level reference model.
module tb_val2_shifter_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  val2_shifter_pipe_if #(.DATA_W(W)) bus ();

  val2_shifter_pipe #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [32:0] exp;
    logic [32:0] gold;
    bit          has_gold;
    int unsigned acc_cyc;
  } item_t;

  item_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned n_in = 0;
  int unsigned n_out = 0;
  bit          lat_mode = 1'b0;
  bit          held = 1'b0;
  logic [32:0] held_val = '0;
  bit          next_has_gold = 1'b0;
  logic [32:0] next_gold = '0;
  bit          rand_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Straight from the ARM shifter rules, W fixed at 32.
  function automatic logic [32:0] model(input logic [31:0] rm, input logic [7:0] rs,
                                        input logic [11:0] so, input logic immd,
                                        input logic mem, input logic cin);
    int n;
    int m;
    logic [63:0] dbl;
    logic [31:0] v;
    logic [32:0] res;
    if (mem) begin
      res = {cin, 20'h0, so};
    end else if (immd) begin
      m   = 2 * int'(so[11:8]);
      dbl = {24'h0, so[7:0], 24'h0, so[7:0]};
      v   = 32'(dbl >> m);
      res = {(m == 0) ? cin : v[31], v};
    end else begin
      n = so[4] ? int'(rs) : int'(so[11:7]);
      if (n == 0) begin
        if (so[4]) res = {cin, rm};
        else begin
          case (so[6:5])
            2'b00:   res = {cin, rm};
            2'b01:   res = {rm[31], 32'h0};
            2'b10:   res = {rm[31], {32{rm[31]}}};
            default: res = {rm[0], cin, rm[31:1]};
          endcase
        end
      end else begin
        case (so[6:5])
          2'b00: begin
            if (n < 32)       res = {rm[5'(32 - n)], rm << n};
            else if (n == 32) res = {rm[0], 32'h0};
            else              res = '0;
          end
          2'b01: begin
            if (n < 32)       res = {rm[5'(n - 1)], rm >> n};
            else if (n == 32) res = {rm[31], 32'h0};
            else              res = '0;
          end
          2'b10: begin
            if (n < 32) res = {rm[5'(n - 1)], 32'($signed(rm) >>> n)};
            else        res = {rm[31], {32{rm[31]}}};
          end
          default: begin
            m = n % 32;
            if (m == 0) res = {rm[31], rm};
            else begin
              dbl = {rm, rm};
              v   = 32'(dbl >> m);
              res = {rm[5'(m - 1)], v};
            end
          end
        endcase
      end
    end
    return res;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor samples on the falling edge: handshakes seen here complete on the next rise.
  initial forever begin
    item_t it;
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && bus.out_valid)
        check("hold", 64'({bus.carry_out, bus.val2_out}), 64'(held_val));
      held     = bus.out_valid && !bus.out_ready;
      held_val = {bus.carry_out, bus.val2_out};
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(bus.out_valid), 64'(1'b0));
        end else begin
          it = sb.pop_front();
          n_out++;
          check("val2", 64'({bus.carry_out, bus.val2_out}), 64'(it.exp));
          if (it.has_gold) check("gold", 64'({bus.carry_out, bus.val2_out}), 64'(it.gold));
          if (lat_mode) check("latency", 64'(cyc - it.acc_cyc), 64'(2));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        it.exp      = model(bus.rm, bus.rs, bus.shift_operand, bus.immd,
                            bus.is_mem_command, bus.carry_in);
        it.gold     = next_gold;
        it.has_gold = next_has_gold;
        it.acc_cyc  = cyc;
        sb.push_back(it);
        n_in++;
      end
    end
  end

  task automatic send(input logic [31:0] r, input logic [7:0] s, input logic [11:0] so,
                      input logic im, input logic mem, input logic cin,
                      input bit hg, input logic [32:0] g);
    bus.rm             = r;
    bus.rs             = s;
    bus.shift_operand  = so;
    bus.immd           = im;
    bus.is_mem_command = mem;
    bus.carry_in       = cin;
    next_has_gold      = hg;
    next_gold          = g;
    bus.in_valid       = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64 && !bus.in_ready; k++) @(negedge clk);
    if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    check("drain", 64'(sb.size()), 64'(0));
    #1;
  endtask

  task automatic send_rand();
    logic [31:0] r;
    logic [7:0]  s;
    case ($urandom_range(0, 3))
      0:       r = 32'h8000_0001;
      1:       r = 32'h8000_0000;
      default: r = $urandom;
    endcase
    case ($urandom_range(0, 4))
      0:       s = 8'd0;
      1:       s = 8'd32;
      2:       s = 8'd33;
      3:       s = 8'($urandom_range(1, 31));
      default: s = 8'($urandom_range(0, 255));
    endcase
    send(r, s, 12'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0,
         $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid       = 1'b0;
    bus.rm             = '0;
    bus.rs             = '0;
    bus.shift_operand  = '0;
    bus.immd           = 1'b0;
    bus.is_mem_command = 1'b0;
    bus.carry_in       = 1'b0;
    bus.out_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    check("rst_val2", 64'(bus.val2_out), 64'(0));
    check("rst_carry", 64'(bus.carry_out), 64'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    @(posedge clk);
    #1;

    // Directed corner cases, back to back with no backpressure.
    lat_mode = 1'b1;
    send(32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b1, {1'b1, 32'hFF00_0000});
    send(32'h3, 8'd0, 12'h060, 1'b0, 1'b0, 1'b1, 1'b1, {1'b1, 32'h8000_0001});
    send(32'h8000_0001, 8'd32, 12'h030, 1'b0, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0});
    send(32'h8000_0001, 8'd33, 12'h030, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 32'h0});
    send(32'h8000_0001, 8'd0, 12'h030, 1'b0, 1'b0, 1'b1, 1'b1, {1'b1, 32'h8000_0001});
    send(32'h8000_0000, 8'd0, 12'h040, 1'b0, 1'b0, 1'b0, 1'b1, {1'b1, 32'hFFFF_FFFF});
    send(32'h1234_5678, 8'd0, 12'hABC, 1'b1, 1'b1, 1'b1, 1'b1, {1'b1, 32'h0000_0ABC});
    send(32'h1234_5678, 8'd0, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b1, {1'b0, 32'h0000_0ABC});
    wait_drain();
    lat_mode = 1'b0;

    // Backpressure: out_ready low across three rising edges while 4 requests queue up.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send($urandom, 8'($urandom_range(0, 40)), 12'($urandom_range(0, 4095)),
               1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_count", 64'(n_out), 64'(n_in));

    // Reset with two requests in flight.
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 8'd4, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send(32'hCAFE_F00D, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(bus.out_valid), 64'(1'b0));
    check("rst_mid_val2", 64'(bus.val2_out), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(bus.out_valid), 64'(1'b0));
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls.
    n_in  = 0;
    n_out = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_rand();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    check("rand_count", 64'(n_out), 64'(n_in));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/val2_shifter_pipe.md
Name: val2_shifter_pipe

Overview:
- Pipelined, parametrised successor to the combinational Val2 operand generator in the execute stage.
- Produces the ARM second ALU operand (val2) together with the shifter carry-out. Shift sources:
  - rotated 8-bit immediate;
  - immediate-amount shift of Rm;
  - register-amount shift of Rm by Rs[7:0];
  - 12-bit memory offset.
- Adds ARM boundary semantics (LSR/ASR #32, RRX, shift amounts ≥ width), carry generation, and a valid/ready handshake with a 2-cycle fixed latency.

Parameters:
- DATA_W, 32, operand width. Power of two, ≥ 16.
- SHAMT_W, $clog2(DATA_W)+1, width of the internal saturated shift-amount field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- rm  in  DATA_W  Rm value
- rs  in  8  Rs[7:0] for register-specified shifts
- shift_operand  in  12  instruction bits [11:0]
- immd  in  1  I bit; rotated-immediate form
- is_mem_command  in  1  LDR/STR offset form
- carry_in  in  1  current CPSR C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- val2_out  out  DATA_W  second operand
- carry_out  out  1  shifter carry-out

Behaviour:
- Reset (async, immediate): out_valid=0, val2_out=0, carry_out=0, all stage valids=0. in_ready=1 once reset deasserts.
- Pipeline:
  - S1 registers the decoded mode, the saturated shift amount (SHAMT_W bits), the shift type, rm and carry_in.
  - S2 registers val2_out and carry_out.
  - Latency is exactly 2 cycles from an accepted request to out_valid under no backpressure. Throughput is 1 per cycle.
- Handshake:
  - A stage advances when it is empty or the stage after it advances.
  - S2 advances on out_ready.
  - in_ready = !s1_valid || s1_advance.
  - A request is accepted on in_valid && in_ready.
  - While out_valid && !out_ready, val2_out and carry_out hold stable.
  - Accepting into S1 and draining S2 in the same cycle is legal and loses no data.
- Mode priority:
  1. is_mem_command: val2 = zero-extended shift_operand; carry = carry_in.
  2. immd: imm8 = shift_operand[7:0], rotated right by 2*shift_operand[11:8]. carry = carry_in if the rotate field is 0, else val2[DATA_W-1].
  3. Register shift, when shift_operand[4]=1: amount = rs[7:0].
  4. Otherwise immediate shift: amount = shift_operand[11:7].
- Shift type is shift_operand[6:5]: LSL=00, LSR=01, ASR=10, ROR=11. Let n be the amount and W = DATA_W.
- Immediate-amount cases:
  - LSL #0: val2 = rm, carry = carry_in.
  - LSR #0 is treated as #W: val2 = 0, carry = rm[W-1].
  - ASR #0 is treated as #W: val2 = all rm[W-1], carry = rm[W-1].
  - ROR #0 is RRX: val2 = {carry_in, rm[W-1:1]}, carry = rm[0].
- Register-amount cases:
  - n=0: val2 = rm, carry = carry_in, for all types.
  - LSL: n<W gives rm<<n with carry rm[W-n]. n=W gives 0 with carry rm[0]. n>W gives 0 with carry 0.
  - LSR: n<W gives rm>>n with carry rm[n-1]. n=W gives 0 with carry rm[W-1]. n>W gives 0 with carry 0.
  - ASR: n≥W gives all sign bits, carry = sign.
  - ROR: n mod W = 0 (n≠0) gives val2 = rm, carry = rm[W-1]. Otherwise rotate right by n mod W, carry = rm[(n mod W)-1].
- Shifts are logarithmic (barrel) structures, not loops.

Decomposition:
- Shared package/defines:
  - shift-type constants LSL/LSR/ASR/ROR;
  - mode encoding MEM, IMM_ROT, SH_IMM, SH_REG;
  - the SHAMT_W formula.
- One sub-module, val2_shift_core: purely combinational (mode, amount, type, rm, carry_in) → (val2, carry). It is instantiated between S1 and S2.

Test Plan:
- Immediate rotate: immd=1, shift_operand=12'h4FF, carry_in=0 → val2=32'hFF000000, carry=1, out_valid exactly 2 cycles after acceptance.
- RRX: shift_operand=12'h060, rm=32'h00000003, carry_in=1 → val2=32'h80000001, carry=1.
- Register shift boundaries, rm=32'h80000001, shift_operand[6:4]=3'b011:
  - rs=32 → val2=0, carry=1.
  - rs=33 → val2=0, carry=0.
  - rs=0 with carry_in=1 → val2=rm, carry=1.
- ASR #0 (immediate), rm=32'h80000000 → val2=32'hFFFFFFFF, carry=1. Memory mode with shift_operand=12'hABC → val2=32'h00000ABC, carry=carry_in.
- Backpressure: stream 4 requests, hold out_ready=0 for 3 cycles → in_ready drops after 2 accepted, outputs stay stable, all 4 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 requests in flight → out_valid=0 immediately, no stale result appears after release.
